// File: rtl/dcache_direct.sv
// Direct-mapped write-back/write-allocate D-cache: 8 lines x 4 words, 128-bit block refill.
// Optional performance counters are enabled with the DCACHE_PERF_CNT_EN macro.
module dcache_direct (
  input  logic         clk,
  input  logic         rst,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic         mem_ready,
  input  logic [127:0] mem_rdata
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  access_cnt,
  output logic [31:0]  miss_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     valid_q, dirty_q;
  logic [24:0]    tag_q  [0:7];
  logic [127:0]   data_q [0:7];

  logic [1:0]     offset;
  logic [2:0]     index;
  logic [24:0]    tag;
  logic [6:0]     bit_lo;
  logic           req, hit, victim_dirty, wr_hit, refill;
  logic [127:0]   line, merged_line;

  assign offset       = proc_addr[1:0];
  assign index        = proc_addr[4:2];
  assign tag          = proc_addr[29:5];
  assign bit_lo       = {offset, 5'd0};
  assign req          = proc_read | proc_write;
  assign line         = data_q[index];
  assign hit          = valid_q[index] && (tag_q[index] == tag);
  assign victim_dirty = valid_q[index] & dirty_q[index];
  // A simultaneous read and write is handled purely as a write.
  assign wr_hit       = (state_q == IDLE) & proc_write & hit;
  assign refill       = (state_q == ALLOCATE) & mem_ready;

  always_comb begin
    merged_line = line;
    merged_line[bit_lo +: 32] = proc_wdata;
  end

  always_comb begin
    state_d    = state_q;
    proc_stall = 1'b0;
    proc_rdata = 32'd0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = 28'd0;
    mem_wdata  = 128'd0;
    case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) begin
            if (!proc_write) proc_rdata = line[bit_lo +: 32];
          end else begin
            proc_stall = 1'b1;
            state_d    = victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        proc_stall = 1'b1;
        mem_write  = 1'b1;
        mem_addr   = {tag_q[index], index};
        mem_wdata  = line;
        if (mem_ready) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        proc_stall = 1'b1;
        mem_read   = 1'b1;
        mem_addr   = proc_addr[29:2];
        if (mem_ready) state_d = IDLE;
      end
      default: begin
        proc_stall = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 8'd0;
      dirty_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (wr_hit) dirty_q[index] <= 1'b1;
      if (refill) begin
        valid_q[index] <= 1'b1;
        dirty_q[index] <= 1'b0;
      end
    end
  end

  // Tag and data arrays carry no reset; the valid bits qualify them.
  always_ff @(posedge clk) begin
    if (refill) begin
      data_q[index] <= mem_rdata;
      tag_q[index]  <= tag;
    end else if (wr_hit) begin
      data_q[index] <= merged_line;
    end
  end

`ifdef DCACHE_PERF_CNT_EN
  logic [31:0] access_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      access_cnt_q <= 32'd0;
      miss_cnt_q   <= 32'd0;
    end else begin
      if ((state_q == IDLE) && req && !proc_stall) access_cnt_q <= access_cnt_q + 32'd1;
      if ((state_q == IDLE) && (state_d != IDLE))  miss_cnt_q   <= miss_cnt_q + 32'd1;
    end
  end

  assign access_cnt = access_cnt_q;
  assign miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_direct.sv
// Directed bench for dcache_direct: cold miss, write hit, dirty eviction, write allocate, reset mid-refill.
module tb_dcache_direct;
  logic         clk = 1'b0;
  logic         rst, proc_read, proc_write, mem_ready;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall, mem_read, mem_write;
  logic [31:0]  proc_rdata;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  access_cnt, miss_cnt;
`endif
  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dcache_direct dut (
    .clk(clk), .rst(rst),
    .proc_read(proc_read), .proc_write(proc_write),
    .proc_addr(proc_addr), .proc_wdata(proc_wdata),
    .proc_stall(proc_stall), .proc_rdata(proc_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
`ifdef DCACHE_PERF_CNT_EN
    , .access_cnt(access_cnt), .miss_cnt(miss_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rd, input logic wr, input logic [29:0] a, input logic [31:0] d);
    proc_read = rd; proc_write = wr; proc_addr = a; proc_wdata = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;
    req(0, 0, 30'd0, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    chk("rst_stall", proc_stall, 0);
    chk("rst_rdata", proc_rdata, 0);
    chk("rst_mread", mem_read, 0);
    chk("rst_mwrite", mem_write, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);

    // Cold read of 0x10: clean miss, ready after 3 ALLOCATE cycles.
    @(negedge clk); req(1, 0, 30'h10, 0); #1;
    chk("cold_c0_stall", proc_stall, 1);
    chk("cold_c0_mread", mem_read, 0);
    @(negedge clk); #1;
    chk("cold_c1_mread", mem_read, 1);
    chk("cold_c1_mwrite", mem_write, 0);
    chk("cold_c1_maddr", mem_addr, 28'h4);
    chk("cold_c1_stall", proc_stall, 1);
    @(negedge clk); #1;
    chk("cold_c2_mread", mem_read, 1);
    @(negedge clk); mem_ready = 1; mem_rdata = {32'd4, 32'd3, 32'd2, 32'd1}; #1;
    chk("cold_c3_mread", mem_read, 1);
    @(negedge clk); mem_ready = 0; #1;
    chk("cold_done_stall", proc_stall, 0);
    chk("cold_done_rdata", proc_rdata, 32'd1);
    chk("cold_done_mread", mem_read, 0);

    // Write hit to 0x11; a stray mem_ready in IDLE must be ignored.
    @(negedge clk); req(0, 1, 30'h11, 32'hDEADBEEF); mem_ready = 1; #1;
    chk("wrhit_stall", proc_stall, 0);
    @(negedge clk); req(1, 0, 30'h11, 0); mem_ready = 0; #1;
    chk("rdback_stall", proc_stall, 0);
    chk("rdback_rdata", proc_rdata, 32'hDEADBEEF);
    chk("rdback_mread", mem_read, 0);

    // Dirty eviction by 0x31 (index 4, tag 1).
    @(negedge clk); req(1, 0, 30'h31, 0); #1;
    chk("evict_c0_stall", proc_stall, 1);
    chk("evict_c0_mwrite", mem_write, 0);
    @(negedge clk); mem_ready = 1; #1;
    chk("evict_wb_mwrite", mem_write, 1);
    chk("evict_wb_mread", mem_read, 0);
    chk("evict_wb_maddr", mem_addr, 28'h4);
    chk("evict_wb_mwdata", mem_wdata, {32'd4, 32'd3, 32'hDEADBEEF, 32'd1});
    @(negedge clk); mem_rdata = {32'h14, 32'h13, 32'h12, 32'h11}; #1;
    chk("evict_al_mwrite", mem_write, 0);
    chk("evict_al_mread", mem_read, 1);
    chk("evict_al_maddr", mem_addr, 28'hC);
    @(negedge clk); mem_ready = 0; #1;
    chk("evict_done_stall", proc_stall, 0);
    chk("evict_done_rdata", proc_rdata, 32'h12);

    // Write miss allocate at 0x40 (index 0, invalid): no writeback.
    @(negedge clk); req(0, 1, 30'h40, 32'h5); #1;
    chk("wmiss_c0_stall", proc_stall, 1);
    @(negedge clk); mem_ready = 1; mem_rdata = {32'h24, 32'h23, 32'h22, 32'h21}; #1;
    chk("wmiss_al_mread", mem_read, 1);
    chk("wmiss_al_mwrite", mem_write, 0);
    chk("wmiss_al_maddr", mem_addr, 28'h10);
    @(negedge clk); mem_ready = 0; #1;
    chk("wmiss_hit_stall", proc_stall, 0);
    @(negedge clk); req(1, 0, 30'h40, 0); #1;
    chk("wmiss_rd0", proc_rdata, 32'h5);
    @(negedge clk); req(1, 0, 30'h41, 0); #1;
    chk("wmiss_rd1", proc_rdata, 32'h22);
    // Evicting with 0x60 proves the line is dirty and holds the merged word.
    @(negedge clk); req(1, 0, 30'h60, 0); #1;
    chk("wmiss_ev_stall", proc_stall, 1);
    @(negedge clk); mem_ready = 1; #1;
    chk("wmiss_ev_mwrite", mem_write, 1);
    chk("wmiss_ev_maddr", mem_addr, 28'h10);
    chk("wmiss_ev_mwdata", mem_wdata, {32'h24, 32'h23, 32'h22, 32'h5});
    @(negedge clk); mem_rdata = {32'h34, 32'h33, 32'h32, 32'h31}; #1;
    chk("wmiss_ev_al_maddr", mem_addr, 28'h18);
    @(negedge clk); mem_ready = 0; #1;
    chk("wmiss_ev_rdata", proc_rdata, 32'h31);

    // Reset during ALLOCATE with a coincident mem_ready: the refill is dropped.
    @(negedge clk); req(1, 0, 30'h04, 0); #1;
    chk("rstmid_c0_stall", proc_stall, 1);
    @(negedge clk); rst = 1; mem_ready = 1; mem_rdata = {4{32'hBAD0BAD0}}; #1;
    chk("rstmid_al_mread", mem_read, 1);
    @(negedge clk); rst = 0; mem_ready = 0; #1;
    chk("rstmid_after_mread", mem_read, 0);
    chk("rstmid_after_mwrite", mem_write, 0);
    chk("rstmid_remiss_stall", proc_stall, 1);
`ifdef DCACHE_PERF_CNT_EN
    chk("cnt_rst_access", access_cnt, 0);
    chk("cnt_rst_miss", miss_cnt, 0);
`endif
    @(negedge clk); mem_ready = 1; mem_rdata = {32'h44, 32'h43, 32'h42, 32'h41}; #1;
    chk("rstmid_re_mread", mem_read, 1);
    chk("rstmid_re_maddr", mem_addr, 28'h1);
    @(negedge clk); mem_ready = 0; #1;
    chk("rstmid_re_stall", proc_stall, 0);
    chk("rstmid_re_rdata", proc_rdata, 32'h41);

    // Three hits then a dirty miss on index 1.
    @(negedge clk); req(1, 0, 30'h05, 0); #1;
    chk("hit5_rdata", proc_rdata, 32'h42);
    @(negedge clk); req(1, 0, 30'h06, 0); #1;
    chk("hit6_rdata", proc_rdata, 32'h43);
    @(negedge clk); req(0, 1, 30'h07, 32'h77); #1;
    chk("hit7_stall", proc_stall, 0);
    @(negedge clk); req(1, 0, 30'h24, 0); #1;
    chk("miss24_stall", proc_stall, 1);
    @(negedge clk); mem_ready = 1; #1;
    chk("miss24_wb_maddr", mem_addr, 28'h1);
    chk("miss24_wb_mwdata", mem_wdata, {32'h77, 32'h43, 32'h42, 32'h41});
    @(negedge clk); mem_rdata = {32'h54, 32'h53, 32'h52, 32'h51}; #1;
    chk("miss24_al_maddr", mem_addr, 28'h9);
    @(negedge clk); mem_ready = 0; #1;
    chk("miss24_rdata", proc_rdata, 32'h51);
    @(negedge clk); req(0, 0, 0, 0); #1;
`ifdef DCACHE_PERF_CNT_EN
    chk("cnt_access", access_cnt, 32'd5);
    chk("cnt_miss", miss_cnt, 32'd2);
`endif
    chk("final_stall", proc_stall, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/dcache_direct.md
# dcache_direct

Direct-mapped, write-back, write-allocate data cache that terminates the core's D-cache port (ren/wen/30-bit word address/32-bit data/stall) and refills from a slow 128-bit block memory. It holds 8 lines of 4 words. It sits between the pipeline's MEM stage and main memory. While a miss is serviced it holds the whole core through `proc_stall`.

## Interface
- No parameters; geometry is fixed: 8 lines, 4 words/line, tag 25 bits.
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `proc_read` in 1 — core read request (DCACHE_ren).
- `proc_write` in 1 — core write request (DCACHE_wen).
- `proc_addr` in 30 — word address; [1:0] word offset, [4:2] index, [29:5] tag.
- `proc_wdata` in 32 — store data.
- `proc_stall` out 1 — high while the current request is not complete.
- `proc_rdata` out 32 — load data, valid when `proc_read` and `!proc_stall`.
- `mem_read` out 1 — block read strobe.
- `mem_write` out 1 — block write strobe.
- `mem_addr` out 28 — block address {tag,index}.
- `mem_wdata` out 128 — victim line, word0 in [31:0].
- `mem_ready` in 1 — one-cycle pulse; the block transfer is done.
- `mem_rdata` in 128 — refill line, sampled when `mem_ready`=1.

## Operation
- Per line: valid, dirty, tag[24:0], data[127:0]. Hit = valid && tag match.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE, no request: `proc_stall`=0 and the memory strobes are low.
- IDLE, hit: `proc_stall`=0 combinationally. A read returns the selected word combinationally. A write updates the selected word and sets dirty at the next edge.
- IDLE, miss, victim dirty: `proc_stall`=1 and the FSM goes to WRITEBACK.
- IDLE, miss, victim clean or invalid: `proc_stall`=1 and the FSM goes to ALLOCATE.
- WRITEBACK: `mem_write`=1, `mem_addr`={victim tag,index}, `mem_wdata`=victim line. On `mem_ready` the FSM goes to ALLOCATE.
- ALLOCATE: `mem_read`=1, `mem_addr`=`proc_addr`[29:2]. On `mem_ready` the line is loaded, valid=1, dirty=0, tag is written, and the FSM goes to IDLE.
- The retried access then hits in IDLE. The write data merge happens on that hit, never during refill.
- `proc_stall`=1 in every non-IDLE state.
- `mem_read` and `mem_write` are decoded from the state register. They are never asserted together.
- `proc_read` and `proc_write` asserted together: treated as a write.
- The request must stay stable while `proc_stall`=1. Behaviour under a changed request is undefined.

## Timing
- Reset: state=IDLE, all valid=0, all dirty=0; tag/data are not reset.
- Reset output values: `proc_stall`=0 with no request, `proc_rdata`=0, `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-miss: at the edge the FSM returns to IDLE and the strobes drop the next cycle. The in-flight refill is discarded and the line stays invalid.
- Hit latency: 0 stall cycles.
- Clean miss: the miss is detected in cycle 0 and `mem_read` is high from cycle 1. With `mem_ready` in cycle k, IDLE is reached in cycle k+1 and `proc_stall`=0 in k+1.
- Dirty miss adds the WRITEBACK duration before ALLOCATE; there are no idle cycles between the two.
- Strobes stay high until the `mem_ready` cycle inclusive and are low in the following cycle.
- `mem_ready` seen in IDLE is ignored.

## Configuration
- `DCACHE_PERF_CNT_EN` defined: adds output ports `access_cnt` [31:0] and `miss_cnt` [31:0], both reset to 0.
  - `access_cnt` increments on every IDLE cycle with a request and `proc_stall`=0, i.e. once per completed access.
  - `miss_cnt` increments on every IDLE→non-IDLE transition.
  - Both wrap modulo 2^32.
- Macro undefined: neither the ports nor the counters exist, and all other behaviour is identical.

## Test plan
- Cold read: after reset, read addr 0x0000_0010. Required: 1 stall cycle, then `mem_read` with `mem_addr`=0x000_0004. The memory returns line {4,3,2,1} with a 3-cycle ready delay, then `proc_rdata`=1 with stall low one cycle after `mem_ready`.
- Write hit then read: write 0xDEADBEEF to 0x11 on a resident line with no stall. Reading 0x11 next cycle returns 0xDEADBEEF and the line is dirty.
- Dirty eviction: after the previous test, read 0x31 (same index, different tag). Required: `mem_write` with `mem_addr`=0x000_0004 and `mem_wdata` word1=0xDEADBEEF, then `mem_read` with `mem_addr`=0x000_000C, then the data is returned.
- Write miss allocate: write 0x5 to clean-miss addr 0x40. Required: refill with no writeback, after which the line holds the refilled words plus word0=0x5, dirty=1.
- Reset mid-refill: assert `rst` during ALLOCATE. Required: strobes low the next cycle, FSM in IDLE, and a reread of the same addr misses again.
- With `DCACHE_PERF_CNT_EN`: 3 hits + 2 misses give `access_cnt`=5 and `miss_cnt`=2.
